stream_max6: RTL and testbench

- Sequential frame-maximum unit for the mini-ALU datapath.
- Accepts a frame of 6-bit operands over a valid/ready stream and drives each operand, together with the running maximum, into the 6-bit greater-than comparator stage.
- Consumes the comparator's single-bit result and reports the frame maximum and its index.
- Sits directly around the comparator: it feeds the comparator's x/y inputs and consumes its greater-than output.

---
 rtl/stream_max6_pkg.sv | 14 +
 rtl/stream_max6.sv | 101 ++++++++++
 tb/tb_stream_max6.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_max6_pkg.sv
// Shared types and sizing for the stream_max6 frame-maximum unit.
package stream_max6_pkg;

    localparam int MAX_W     = 6;
    localparam int CNT_W_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FIRST = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/stream_max6.sv
// Frame-maximum sequencer wrapped around an external 6-bit greater-than comparator.
//
// state | meaning
// IDLE  | waiting for start
// FIRST | accepting operand 0, seeds the running maximum
// RUN   | accepting operands 1..len-1, replace on strict greater-than
// DONE  | one-cycle result pulse
module stream_max6
    import stream_max6_pkg::*;
#(
    parameter int W     = MAX_W,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] frame_len,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic [W-1:0]     cmp_x,
    output logic [W-1:0]     cmp_y,
    input  logic             cmp_gr,
    output logic [W-1:0]     max_out,
    output logic [CNT_W-1:0] max_idx,
    output logic             done,
    output logic             busy
);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] len_q;
    logic             accept;

    // Handshake flags come from the state register alone, so in_ready never depends on in_valid.
    assign in_ready = (state == S_FIRST) || (state == S_RUN);
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);
    assign accept   = in_valid & in_ready;

    assign cmp_x = in_data;
    assign cmp_y = max_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            max_out <= '0;
            max_idx <= '0;
            count   <= '0;
            len_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (frame_len != '0) begin
                            len_q <= frame_len;
                            count <= '0;
                            state <= S_FIRST;
                        end else begin
                            max_out <= '0;
                            max_idx <= '0;
                            state   <= S_DONE;
                        end
                    end
                end
                S_FIRST: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (accept) begin
                        max_out <= in_data;
                        max_idx <= '0;
                        count   <= CNT_W'(1);
                        state   <= (len_q == CNT_W'(1)) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (accept) begin
                        if (cmp_gr) begin
                            max_out <= in_data;
                            max_idx <= count;
                        end
                        count <= count + CNT_W'(1);
                        if (count == len_q - CNT_W'(1)) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_max6.sv
// Self-checking bench for stream_max6 with a behavioural comparator and max/index reference model.
module tb_stream_max6;

    localparam int W     = 6;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] frame_len;
    logic             abort;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic [W-1:0]     cmp_x;
    logic [W-1:0]     cmp_y;
    logic             cmp_gr;
    logic [W-1:0]     max_out;
    logic [CNT_W-1:0] max_idx;
    logic             done;
    logic             busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [W-1:0] fd[$];

    stream_max6 #(.W(W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .frame_len (frame_len),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .cmp_x     (cmp_x),
        .cmp_y     (cmp_y),
        .cmp_gr    (cmp_gr),
        .max_out   (max_out),
        .max_idx   (max_idx),
        .done      (done),
        .busy      (busy)
    );

    // Stand-in for the parent's comparator stage.
    assign cmp_gr = (cmp_x > cmp_y);

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // Reference: frame maximum with earliest index among equal maxima.
    task automatic ref_max(output logic [W-1:0] mv, output logic [CNT_W-1:0] mi);
        mv = '0;
        mi = '0;
        for (int i = 0; i < fd.size(); i++) begin
            if (i == 0 || fd[i] > mv) begin
                mv = fd[i];
                mi = CNT_W'(i);
            end
        end
    endtask

    // Drives a whole frame from fd; returns at the negedge where done was seen (or the bound ran out).
    task automatic send_frame(input int len, input int gap, output int lat, output bit to);
        int  b;
        int  t0;
        logic rdy;
        to = 1'b0;
        frame_len = CNT_W'(len);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0 = cyc;
        for (int i = 0; i < len; i++) begin
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = fd[i];
            b = 0;
            do begin
                @(negedge clk);
                rdy = in_ready;
                @(posedge clk);
                #1;
                b++;
            end while (!rdy && b < 50);
            if (!rdy) to = 1'b1;
        end
        in_valid = 1'b0;
        b = 0;
        @(negedge clk);
        while (!done && b < 50) begin
            @(negedge clk);
            b++;
        end
        if (!done) to = 1'b1;
        lat = cyc - t0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; frame_len = '0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
        #3;
        checks++; if (max_out !== 6'd0) begin failures++; $display("FAIL reset_max_out got=%0d exp=0", max_out); end
        checks++; if (max_idx !== 4'd0) begin failures++; $display("FAIL reset_max_idx got=%0d exp=0", max_idx); end
        checks++; if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            failures++; $display("FAIL reset_flags got done=%b busy=%b in_ready=%b exp=0,0,0", done, busy, in_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat; bit to;
        fd = '{6'd12, 6'd45, 6'd7, 6'd30};
        send_frame(4, 0, lat, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL basic_timeout got=%b exp=0", to); end
        checks++; if (lat != 4) begin failures++; $display("FAIL basic_latency got=%0d exp=4", lat); end
        checks++; if (max_out !== 6'd45) begin failures++; $display("FAIL basic_max got=%0d exp=45", max_out); end
        checks++; if (max_idx !== 4'd1) begin failures++; $display("FAIL basic_idx got=%0d exp=1", max_idx); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL basic_after_done got done=%b busy=%b exp=0,0", done, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_tie_first();
        int lat; bit to;
        fd = '{6'd63, 6'd63, 6'd0};
        send_frame(3, 0, lat, to);
        checks++; if (to !== 1'b0 || max_out !== 6'd63 || max_idx !== 4'd0) begin
            failures++; $display("FAIL tie got to=%b max=%0d idx=%0d exp=0,63,0", to, max_out, max_idx);
        end
        @(negedge clk); @(posedge clk); #1;
        fd = '{6'd5};
        send_frame(1, 0, lat, to);
        checks++; if (to !== 1'b0 || lat != 1) begin failures++; $display("FAIL single_latency got to=%b lat=%0d exp=0,1", to, lat); end
        checks++; if (max_out !== 6'd5 || max_idx !== 4'd0) begin
            failures++; $display("FAIL single_result got max=%0d idx=%0d exp=5,0", max_out, max_idx);
        end
        @(negedge clk); @(posedge clk); #1;
    endtask

    task automatic test_zero_stall();
        int lat; bit to;
        frame_len = '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checks++; if (done !== 1'b1 || in_ready !== 1'b0) begin
            failures++; $display("FAIL zero_len_flags got done=%b in_ready=%b exp=1,0", done, in_ready);
        end
        checks++; if (max_out !== 6'd0 || max_idx !== 4'd0) begin
            failures++; $display("FAIL zero_len_clear got max=%0d idx=%0d exp=0,0", max_out, max_idx);
        end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL zero_len_end got done=%b busy=%b exp=0,0", done, busy);
        end
        @(posedge clk); #1;
        fd = '{6'd1, 6'd2, 6'd3};
        send_frame(3, 2, lat, to);
        checks++; if (to !== 1'b0 || lat != 9) begin failures++; $display("FAIL stall_latency got to=%b lat=%0d exp=0,9", to, lat); end
        checks++; if (max_out !== 6'd3 || max_idx !== 4'd2) begin
            failures++; $display("FAIL stall_result got max=%0d idx=%0d exp=3,2", max_out, max_idx);
        end
        @(negedge clk); @(posedge clk); #1;
    endtask

    task automatic test_abort_and_start();
        bit seen;
        frame_len = 4'd5;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1; in_data = 6'd10;
        @(posedge clk); #1;
        in_data = 6'd20;
        @(posedge clk); #1;
        in_data = 6'd60; abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL abort_idle got busy=%b in_ready=%b done=%b exp=0,0,0", busy, in_ready, done);
        end
        checks++; if (max_out !== 6'd20) begin failures++; $display("FAIL abort_not_consumed got max=%0d exp=20", max_out); end
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_done got seen=%b exp=0", seen); end
        @(posedge clk); #1;

        frame_len = 4'd3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1; in_data = 6'd4;
        @(posedge clk); #1;
        in_valid = 1'b0; start = 1'b1; frame_len = 4'd1;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1; in_data = 6'd9;
        @(posedge clk); #1;
        in_data = 6'd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (done !== 1'b1 || max_out !== 6'd9 || max_idx !== 4'd1) begin
            failures++; $display("FAIL busy_start_ignored got done=%b max=%0d idx=%0d exp=1,9,1", done, max_out, max_idx);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        int lat; bit to;
        frame_len = 4'd6;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 6'(50 + i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (max_out !== 6'd0 || max_idx !== 4'd0) begin
            failures++; $display("FAIL async_reset_data got max=%0d idx=%0d exp=0,0", max_out, max_idx);
        end
        checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL async_reset_flags got busy=%b in_ready=%b done=%b exp=0,0,0", busy, in_ready, done);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        fd = '{6'd9, 6'd8};
        send_frame(2, 0, lat, to);
        checks++; if (to !== 1'b0 || lat != 2 || max_out !== 6'd9 || max_idx !== 4'd0) begin
            failures++; $display("FAIL after_reset got to=%b lat=%0d max=%0d idx=%0d exp=0,2,9,0", to, lat, max_out, max_idx);
        end
        @(negedge clk); @(posedge clk); #1;
    endtask

    task automatic test_random();
        int lat; bit to; int len; int gap;
        logic [W-1:0] exp_max;
        logic [CNT_W-1:0] exp_idx;
        for (int f = 0; f < 30; f++) begin
            len = $urandom_range(1, 15);
            gap = $urandom_range(0, 2);
            fd.delete();
            for (int i = 0; i < len; i++) begin
                fd.push_back(W'((f % 2 == 1) ? $urandom_range(0, 3) : $urandom_range(0, 63)));
            end
            ref_max(exp_max, exp_idx);
            send_frame(len, gap, lat, to);
            checks++; if (to !== 1'b0 || lat != len * (gap + 1)) begin
                failures++; $display("FAIL rand_latency frame=%0d got to=%b lat=%0d exp=0,%0d", f, to, lat, len * (gap + 1));
            end
            checks++; if (max_out !== exp_max || max_idx !== exp_idx) begin
                failures++; $display("FAIL rand_result frame=%0d len=%0d got max=%0d idx=%0d exp=%0d,%0d", f, len, max_out, max_idx, exp_max, exp_idx);
            end
            @(negedge clk); @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie_first();
        test_zero_stall();
        test_abort_and_start();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
